diffusion_div_feeder: RTL and testbench
=======================================

# diffusion_div_feeder

Request sequencer sitting directly upstream of the 32-bit iterative divider in the diffusion datapath. It accepts push requests (residual, out-degree, node tag) on a valid/ready stream and issues one start pulse per request to the divider. It qualifies the divider's completion flag and returns the per-neighbour share (residual / degree) with its tag on an output valid/ready stream. Divide-by-zero is resolved locally, and a watchdog guards against a hung divider.

## Interface
Parameters:
- MIN_WAIT, 32: cycles after div_start during which div_ok is ignored (covers stale ok).
- TIMEOUT, 64: cycles after div_start with no qualified ok before aborting with error; must exceed MIN_WAIT.

Ports:
- clk  in  1  single clock; all logic rises on posedge clk.
- reset_n  in  1  reset is asynchronous and active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request (high only in IDLE).
- in_residual  in  32  dividend.
- in_degree  in  32  divisor.
- in_tag  in  32  node id carried through unchanged.
- div_start  out  1  one-cycle start pulse to divider.
- div_a  out  32  dividend to divider, registered.
- div_b  out  32  divisor to divider, registered.
- div_d  in  32  divider quotient.
- div_ok  in  1  divider done flag (may be high outside a request).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_share  out  32  quotient.
- out_tag  out  32  tag of the request.
- out_err  out  1  1 = divide-by-zero or timeout; out_share is then 0.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD. Only one request is ever outstanding.
- IDLE: in_ready=1. On in_valid&in_ready, latch residual/degree/tag.
  - degree==0 -> HOLD with share=0, err=1.
  - otherwise -> ISSUE.
- ISSUE: div_start=1 for exactly this cycle, with div_a/div_b already holding the latched operands. Clear the wait counter. -> WAIT.
- WAIT: counter increments each cycle.
  - div_ok is ignored while counter < MIN_WAIT.
  - First cycle with counter >= MIN_WAIT and div_ok=1: capture div_d into out_share, err=0 -> HOLD.
  - counter reaches TIMEOUT with no capture: share=0, err=1 -> HOLD.
- HOLD: out_valid=1; out_share/out_tag/out_err stable. On out_ready -> IDLE.
- div_a/div_b hold the last operands until the next accept. Tag is never modified.

## Timing
- Reset values: in_ready=0 while reset_n low, then 1 in IDLE. div_start=0, div_a=0, div_b=0, out_valid=0, out_share=0, out_tag=0, out_err=0. State is IDLE, counter=0.
- Latency, normal path:
  - Accept at cycle 0.
  - div_start high in cycle 1.
  - The divider raises ok 33 cycles after start.
  - out_valid rises the cycle after the qualified ok. Nominally cycle 35.
- Latency, degree==0: out_valid at cycle 1.
- Throughput: a new request is accepted no earlier than the cycle after the out_valid&out_ready handshake. in_ready is 0 in HOLD, even when out_ready=1.
- div_ok high during IDLE, ISSUE or HOLD has no effect.
- reset_n low mid-operation: immediate return to IDLE and all outputs to reset values. The pending request is dropped and not replayed. Any divider result still in flight is ignored, because a new request waits MIN_WAIT again.
- out_ready high while out_valid=0 has no effect. out_valid never deasserts without a handshake or reset.

## Configuration
- DIV_FEEDER_BYPASS_ONE_EN defined: a request with in_degree==1 skips the divider. It goes IDLE -> HOLD with share=in_residual and err=0, out_valid at cycle 1, and div_start is not pulsed.
- DIV_FEEDER_BYPASS_ONE_EN undefined: degree==1 goes through the divider like any nonzero degree.

## Test plan
- residual=100, degree=7, tag=0x55 -> one div_start pulse. With a divider model returning d=14 and ok at start+33: out_share=14, out_tag=0x55, out_err=0, out_valid 35 cycles after accept.
- degree=0, residual=0xFFFF, tag=3 -> no div_start; out_valid next cycle with share=0, err=1, tag=3.
- div_ok held high from before the request, with d=0xDEAD until start+33 and then 9 -> stale ok ignored during MIN_WAIT; out_share=9.
- Divider model never asserts ok -> out_err=1 and share=0 at TIMEOUT cycles after start. Next request then completes normally.
- out_ready low for 10 cycles after out_valid -> outputs stable; in_ready=0 with in_valid=1 held. Accept occurs the cycle after the handshake.
- reset_n pulsed low at cycle 10 of WAIT -> all outputs at reset values. A following request 1000/10 returns 100. With DIV_FEEDER_BYPASS_ONE_EN defined, degree=1 with residual=77 returns 77 at cycle 1 with no div_start.

Source files
------------

// File: rtl/diffusion_div_feeder_if.sv
// Request, divider and result streams of diffusion_div_feeder bundled as one interface.
// The slave modport is the feeder's view; master is the surrounding environment's view.
interface diffusion_div_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_residual;
    logic [31:0] in_degree;
    logic [31:0] in_tag;

    logic        div_start;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_d;
    logic        div_ok;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_share;
    logic [31:0] out_tag;
    logic        out_err;

    modport slave (
        input  in_valid, in_residual, in_degree, in_tag,
        output in_ready,
        output div_start, div_a, div_b,
        input  div_d, div_ok,
        output out_valid, out_share, out_tag, out_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_residual, in_degree, in_tag,
        input  in_ready,
        input  div_start, div_a, div_b,
        output div_d, div_ok,
        input  out_valid, out_share, out_tag, out_err,
        output out_ready
    );
endinterface

// File: rtl/diffusion_div_feeder.sv
// Sequences residual/degree requests through the iterative divider and returns the share.
// Optional build macro DIV_FEEDER_BYPASS_ONE_EN: degree==1 skips the divider entirely.
module diffusion_div_feeder #(
    parameter int MIN_WAIT = 32,
    parameter int TIMEOUT  = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    diffusion_div_feeder_if.slave  feed
);

    localparam int CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] MinWaitC     = CntW'(MIN_WAIT);
    localparam logic [CntW-1:0] TimeoutLastC = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     div_a_q, div_a_d;
    logic [31:0]     div_b_q, div_b_d;
    logic [31:0]     share_q, share_d;
    logic [31:0]     tag_q, tag_d;
    logic            err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_a_q <= '0;
            div_b_q <= '0;
            share_q <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_a_q <= div_a_d;
            div_b_q <= div_b_d;
            share_q <= share_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_a_d = div_a_q;
        div_b_d = div_b_q;
        share_d = share_q;
        tag_d   = tag_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (feed.in_valid) begin
                    div_a_d = feed.in_residual;
                    div_b_d = feed.in_degree;
                    tag_d   = feed.in_tag;
                    if (feed.in_degree == 32'd0) begin
                        share_d = '0;
                        err_d   = 1'b1;
                        state_d = HOLD;
`ifdef DIV_FEEDER_BYPASS_ONE_EN
                    end else if (feed.in_degree == 32'd1) begin
                        share_d = feed.in_residual;
                        err_d   = 1'b0;
                        state_d = HOLD;
`endif
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end

            // An ok seen before MIN_WAIT cycles may belong to an earlier, abandoned request.
            WAIT: begin
                if ((cnt_q >= MinWaitC) && feed.div_ok) begin
                    share_d = feed.div_d;
                    err_d   = 1'b0;
                    state_d = HOLD;
                end else if (cnt_q == TimeoutLastC) begin
                    share_d = '0;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HOLD: begin
                if (feed.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // in_ready is gated by reset_n so it reads low for the whole reset assertion.
    assign feed.in_ready  = reset_n && (state_q == IDLE);
    assign feed.div_start = (state_q == ISSUE);
    assign feed.div_a     = div_a_q;
    assign feed.div_b     = div_b_q;
    assign feed.out_valid = (state_q == HOLD);
    assign feed.out_share = share_q;
    assign feed.out_tag   = tag_q;
    assign feed.out_err   = err_q;

endmodule

// File: tb/tb_diffusion_div_feeder.sv
// Self-checking bench for diffusion_div_feeder with a behavioural divider and reference model.
// Honours DIV_FEEDER_BYPASS_ONE_EN when computing expected latency and divider usage.
module tb_diffusion_div_feeder;

    localparam int MinWait = 32;
    localparam int Timeout = 64;
`ifdef DIV_FEEDER_BYPASS_ONE_EN
    localparam bit BypassOne = 1'b1;
`else
    localparam bit BypassOne = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   cyc;
    int   assertCount;
    int   failCount;

    // Divider model: 0 = ok from start+divDelay with true quotient, 1 = stale ok, 2 = never ok
    int   divMode;
    int   divDelay;
    int   since;

    diffusion_div_feeder_if feed ();

    diffusion_div_feeder #(
        .MIN_WAIT (MinWait),
        .TIMEOUT  (Timeout)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .feed    (feed.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) since = -1;
        else if (feed.div_start) since = 0;
        else if (since >= 0) since = since + 1;
        case (divMode)
            0: begin
                feed.div_ok = (since >= divDelay);
                feed.div_d  = (feed.div_b == 32'd0) ? 32'd0 : feed.div_a / feed.div_b;
            end
            1: begin
                feed.div_ok = 1'b1;
                feed.div_d  = (since >= 33) ? 32'd9 : 32'hDEAD;
            end
            default: begin
                feed.div_ok = 1'b0;
                feed.div_d  = 32'd0;
            end
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    // Reference: shares are plain integer division; the first usable ok is MIN_WAIT+1 cycles after start.
    function automatic int refLatency(input logic [31:0] deg, input int delay);
        if (deg == 32'd0 || (BypassOne && deg == 32'd1)) return 1;
        return 2 + ((delay > MinWait + 1) ? delay : MinWait + 1);
    endfunction

    task automatic applyStimulus(input string name, input logic [31:0] res, input logic [31:0] deg,
                                 input logic [31:0] reqTag, input logic [31:0] expShare,
                                 input logic expErr, input int expLat, input int expStarts,
                                 input int holdCycles, output int lat);
        int n;
        int acc;
        int starts;
        bit stable;
        logic [31:0] obsA;
        logic [31:0] obsB;
        lat = -1;
        obsA = '0;
        obsB = '0;
        @(negedge clk);
        feed.in_valid    = 1'b1;
        feed.in_residual = res;
        feed.in_degree   = deg;
        feed.in_tag      = reqTag;
        n = 0;
        while (!feed.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!feed.in_ready) begin
            checkOutput({name, "_accept_timeout"}, 32'd0, 32'd1);
            feed.in_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(negedge clk);
        feed.in_valid = 1'b0;
        starts = 0;
        n = 0;
        while (!feed.out_valid && n < 200) begin
            if (feed.div_start) begin
                starts++;
                obsA = feed.div_a;
                obsB = feed.div_b;
            end
            @(negedge clk);
            n++;
        end
        if (!feed.out_valid) begin
            checkOutput({name, "_result_timeout"}, 32'd0, 32'd1);
            return;
        end
        lat = cyc - acc;
        checkOutput({name, "_share"}, feed.out_share, expShare);
        checkOutput({name, "_tag"}, feed.out_tag, reqTag);
        checkOutput({name, "_err"}, 32'(feed.out_err), 32'(expErr));
        checkOutput({name, "_starts"}, 32'(starts), 32'(expStarts));
        if (expLat >= 0) checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
        if (starts > 0) begin
            checkOutput({name, "_div_a"}, obsA, res);
            checkOutput({name, "_div_b"}, obsB, deg);
        end
        if (holdCycles > 0) begin
            feed.in_valid    = 1'b1;
            feed.in_residual = 32'h1111;
            feed.in_degree   = 32'd2;
            stable = 1'b1;
            for (int i = 0; i < holdCycles; i++) begin
                @(negedge clk);
                if (!feed.out_valid || feed.out_share !== expShare || feed.out_tag !== reqTag ||
                    feed.out_err !== expErr || feed.in_ready !== 1'b0)
                    stable = 1'b0;
            end
            checkOutput({name, "_hold_stable"}, 32'(stable), 32'd1);
        end
        feed.out_ready = 1'b1;
        @(negedge clk);
        feed.out_ready = 1'b0;
        checkOutput({name, "_released"}, 32'(feed.out_valid), 32'd0);
        checkOutput({name, "_ready_after"}, 32'(feed.in_ready), 32'd1);
        feed.in_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        logic [31:0] res;
        logic [31:0] deg;
        logic [31:0] rtag;
        int sel;
        int hold;

        cyc         = 0;
        assertCount = 0;
        failCount   = 0;
        divMode     = 0;
        divDelay    = 33;
        reset_n     = 1'b0;
        feed.in_valid    = 1'b0;
        feed.in_residual = '0;
        feed.in_degree   = '0;
        feed.in_tag      = '0;
        feed.out_ready   = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(feed.in_ready), 32'd0);
        checkOutput("rst_div_start", 32'(feed.div_start), 32'd0);
        checkOutput("rst_div_a", feed.div_a, 32'd0);
        checkOutput("rst_div_b", feed.div_b, 32'd0);
        checkOutput("rst_out_valid", 32'(feed.out_valid), 32'd0);
        checkOutput("rst_out_share", feed.out_share, 32'd0);
        checkOutput("rst_out_tag", feed.out_tag, 32'd0);
        checkOutput("rst_out_err", 32'(feed.out_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", 32'(feed.in_ready), 32'd1);

        $display("[TB] directed requests");
        applyStimulus("basic", 32'd100, 32'd7, 32'h55, 32'd14, 1'b0, 35, 1, 0, lat);
        applyStimulus("divzero", 32'hFFFF, 32'd0, 32'd3, 32'd0, 1'b1, 1, 0, 0, lat);

        divMode = 1;
        applyStimulus("stale", 32'd500, 32'd3, 32'h77, 32'd9, 1'b0, 35, 1, 0, lat);

        divMode = 2;
        applyStimulus("timeout", 32'd1234, 32'd5, 32'h99, 32'd0, 1'b1, -1, 1, 0, lat);
        checkOutput("timeout_window", 32'((lat - 1 >= Timeout) && (lat - 1 <= Timeout + 2)), 32'd1);
        divMode = 0;
        applyStimulus("after_timeout", 32'd1234, 32'd5, 32'h9A, 32'd246, 1'b0, 35, 1, 0, lat);

        applyStimulus("backpressure", 32'd600, 32'd6, 32'h66, 32'd100, 1'b0, 35, 1, 10, lat);

        $display("[TB] reset during WAIT");
        @(negedge clk);
        feed.in_valid    = 1'b1;
        feed.in_residual = 32'd4242;
        feed.in_degree   = 32'd3;
        feed.in_tag      = 32'hAB;
        n = 0;
        while (!feed.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        feed.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(feed.in_ready), 32'd0);
        checkOutput("midrst_div_start", 32'(feed.div_start), 32'd0);
        checkOutput("midrst_div_a", feed.div_a, 32'd0);
        checkOutput("midrst_div_b", feed.div_b, 32'd0);
        checkOutput("midrst_out_valid", 32'(feed.out_valid), 32'd0);
        checkOutput("midrst_out_tag", feed.out_tag, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus("post_reset", 32'd1000, 32'd10, 32'h10, 32'd100, 1'b0, 35, 1, 0, lat);

        if (BypassOne)
            applyStimulus("degree_one", 32'd77, 32'd1, 32'h21, 32'd77, 1'b0, 1, 0, 0, lat);
        else
            applyStimulus("degree_one", 32'd77, 32'd1, 32'h21, 32'd77, 1'b0, 35, 1, 0, lat);

        $display("[TB] randomized requests");
        for (int i = 0; i < 20; i++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0)      deg = 32'd0;
            else if (sel == 1) deg = 32'd1;
            else if (sel == 2) deg = $urandom;
            else               deg = $urandom_range(2, 1000);
            res      = $urandom;
            rtag     = $urandom;
            divDelay = $urandom_range(5, 50);
            hold     = $urandom_range(0, 3);
            applyStimulus($sformatf("rand%0d", i), res, deg, rtag,
                          (deg == 32'd0) ? 32'd0 : res / deg, (deg == 32'd0),
                          refLatency(deg, divDelay),
                          (refLatency(deg, divDelay) == 1) ? 0 : 1, hold, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed %0d cycles expected fewer", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
